// File: rtl/switch_debouncer_if.sv
// Switch debouncer signal bundle: raw pins in, clean levels and edge strobes out.
interface switch_debouncer_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] sw_raw;
    logic [N_CH-1:0] sw_level;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;

    // Board side: drives the raw pins, consumes the debounced outputs.
    modport master (
        output sw_raw,
        input  sw_level,
        input  sw_rise,
        input  sw_fall
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw_level,
        output sw_rise,
        output sw_fall
    );
endinterface

// File: rtl/switch_debouncer.sv
// Multi-channel switch/button debouncer.
// Each raw pin goes through a two-flop synchroniser, then a per-channel
// IDLE/CHECK FSM that only lets the level follow once the synchronised value
// has differed from the current level for STABLE_CYCLES consecutive cycles.
// Level changes are accompanied by a single-cycle rise or fall strobe.
module switch_debouncer #(
    parameter int N_CH          = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_debouncer_if.slave    sw
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Terminal count: reaching it while still different commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_CH-1:0]  sync0_q, sync0_d;
    logic [N_CH-1:0]  sync1_q, sync1_d;
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  rise_q,  rise_d;
    logic [N_CH-1:0]  fall_q,  fall_d;
    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];

    // Next-state logic: synchroniser shift plus one independent FSM per channel.
    always_comb begin
        sync0_d = sw.sw_raw;
        sync1_d = sync0_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (sync1_q[i] != level_q[i]) begin
                        cnt_d[i]   = CNT_ONE;
                        state_d[i] = CHECK;
                    end
                end
                CHECK: begin
                    if (sync1_q[i] == level_q[i]) begin
                        // Input bounced back before it was stable: drop the pending change.
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        level_d[i] = sync1_q[i];
                        rise_d[i]  = sync1_q[i];
                        fall_d[i]  = ~sync1_q[i];
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything, discarding any pending change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sw.sw_level = level_q;
    assign sw.sw_rise  = rise_q;
    assign sw.sw_fall  = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer with STABLE_CYCLES=4, N_CH=2.
// Expected per-cycle outputs come from the stated latency rule: a raw change
// first sampled on edge e shows on sw_level at edge e+5 with a coincident strobe.
module tb_switch_debouncer;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q [$];

    switch_debouncer_if #(.N_CH(2)) sw_if ();

    switch_debouncer #(
        .N_CH         (2),
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] l, input logic [1:0] r, input logic [1:0] f);
        exp_t e;
        e.lvl  = l;
        e.rise = r;
        e.fall = f;
        return e;
    endfunction

    function automatic exp_t got();
        return mk(sw_if.sw_level, sw_if.sw_rise, sw_if.sw_fall);
    endfunction

    // Apply raw value, advance one edge, settle before sampling.
    task automatic cyc(input logic [1:0] raw);
        sw_if.sw_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(2'b00, 2'b00, 2'b00));
        for (int k = 0; k < 3; k++) begin
            cyc(2'b00);
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_rise();
        exp_t e, g;
        for (int k = 0; k < 10; k++)
            exp_q.push_back(mk((k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00));
        for (int k = 0; k < 10; k++) begin
            cyc(2'b01);
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL single_rise k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_short_pulse();
        exp_t e, g;
        for (int k = 0; k < 10; k++) exp_q.push_back(mk(2'b01, 2'b00, 2'b00));
        for (int k = 0; k < 10; k++) begin
            cyc({(k < 3), 1'b1});
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL short_pulse k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e, g;
        logic [0:5] train;
        train = 6'b101101;
        // Return ch0 to 0 first; the fall strobe lands 5 edges later.
        for (int k = 0; k < 8; k++)
            exp_q.push_back(mk((k >= 5) ? 2'b00 : 2'b01, 2'b00, (k == 5) ? 2'b01 : 2'b00));
        for (int k = 0; k < 8; k++) begin
            cyc(2'b00);
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL bounce_pre k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
        // Last 0->1 of the train is at index 5, so the level rises at index 10.
        for (int k = 0; k < 14; k++)
            exp_q.push_back(mk((k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00));
        for (int k = 0; k < 14; k++) begin
            cyc({1'b0, (k < 6) ? train[k] : 1'b1});
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL bounce k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_simultaneous_fall();
        exp_t e, g;
        for (int k = 0; k < 8; k++)
            exp_q.push_back(mk((k >= 5) ? 2'b11 : 2'b01, (k == 5) ? 2'b10 : 2'b00, 2'b00));
        for (int k = 0; k < 8; k++)
            exp_q.push_back(mk((k >= 5) ? 2'b00 : 2'b11, 2'b00, (k == 5) ? 2'b11 : 2'b00));
        for (int k = 0; k < 16; k++) begin
            cyc((k < 8) ? 2'b11 : 2'b00);
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL simul_fall k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e, g;
        // Three edges of raw=01 start a count, then two reset edges, then release.
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(2'b00, 2'b00, 2'b00));
        for (int k = 0; k < 8; k++)
            exp_q.push_back(mk((k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00));
        for (int k = 0; k < 13; k++) begin
            rst = (k == 3 || k == 4);
            cyc(2'b01);
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_mid k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_min_pulse();
        exp_t e, g;
        // A pulse of exactly STABLE_CYCLES is accepted: rise at 5, fall at 9.
        for (int k = 0; k < 12; k++)
            exp_q.push_back(mk({(k >= 5 && k < 9), 1'b1},
                               (k == 5) ? 2'b10 : 2'b00,
                               (k == 9) ? 2'b10 : 2'b00));
        for (int k = 0; k < 12; k++) begin
            cyc({(k < 4), 1'b1});
            e = exp_q.pop_front();
            g = got();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL min_pulse k=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                         k, g.lvl, g.rise, g.fall, e.lvl, e.rise, e.fall);
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        sw_if.sw_raw = 2'b00;
        test_reset();
        test_single_rise();
        test_short_pulse();
        test_bounce();
        test_simultaneous_fall();
        test_reset_mid_count();
        test_min_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
